mem_arbiter: RTL and testbench

Two-requester arbiter that shares one unified, variable-latency memory port between the instruction-fetch stage and the load/store (data) stage of the MIPS datapath. It serialises accesses with round-robin priority, checks alignment before issuing, enforces a memory timeout, and returns read data with a one-cycle valid pulse. It sits between the pipeline's fetch/MEM stages and the memory array that replaces the separate instruction and data memories.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the unified fetch/data memory arbiter.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } arb_state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Size 11 is never a legal data access, whatever the address.
  function automatic logic d_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a tie goes to whichever requester was not granted last.
module rr_arb2
  import mem_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = if_req | d_req;
    if (if_req && d_req) begin
      gnt_id = ~last_gnt;
    end else if (d_req) begin
      gnt_id = REQ_D;
    end else begin
      gnt_id = REQ_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store accesses onto one variable-latency memory port,
// with alignment screening, an access timeout and registered one-cycle responses.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_sign,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t  state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic        gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        mem_req_q, mem_req_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        mem_sign_q, mem_sign_d;

  logic        if_valid_q, if_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_err_q, if_err_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  logic        gnt_valid, gnt_id;
  logic        resp_fire, resp_id, resp_err, grant_err;
  logic [31:0] resp_rdata;

  rr_arb2 u_rr (
    .if_req   (if_req),
    .d_req    (d_req),
    .last_gnt (last_gnt_q),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    mem_sign_d  = mem_sign_q;
    resp_fire   = 1'b0;
    resp_id     = gnt_q;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    grant_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          last_gnt_d = gnt_id;
          gnt_d      = gnt_id;
          cnt_d      = '0;
          if (gnt_id == REQ_IF) begin
            mem_addr_d  = if_addr;
            mem_write_d = 1'b0;
            mem_wdata_d = '0;
            mem_size_d  = SIZE_WORD;
            mem_sign_d  = 1'b0;
            grant_err   = (if_addr[1:0] != 2'b00);
          end else begin
            mem_addr_d  = d_addr;
            mem_write_d = d_write;
            mem_wdata_d = d_wdata;
            mem_size_d  = d_size;
            mem_sign_d  = d_sign;
            grant_err   = d_misaligned(d_size, d_addr[1:0]);
          end
          // A rejected access answers immediately and never touches memory.
          if (grant_err) begin
            state_d   = RESP;
            resp_fire = 1'b1;
            resp_id   = gnt_id;
            resp_err  = 1'b1;
          end else begin
            state_d   = ISSUE;
            mem_req_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          state_d    = RESP;
          resp_fire  = 1'b1;
          resp_rdata = mem_write_q ? 32'h0 : mem_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if_valid_d = resp_fire && (resp_id == REQ_IF);
    if_rdata_d = if_valid_d ? resp_rdata : 32'h0;
    if_err_d   = if_valid_d && resp_err;
    d_valid_d  = resp_fire && (resp_id == REQ_D);
    d_rdata_d  = d_valid_d ? resp_rdata : 32'h0;
    d_err_d    = d_valid_d && resp_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= REQ_D;
      gnt_q       <= REQ_IF;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      mem_sign_q  <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      mem_sign_q  <= mem_sign_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign mem_sign  = mem_sign_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_sign;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  // memory model controls
  int          mem_lat   = 0;
  bit          mem_never = 0;
  logic [31:0] mem_data  = 32'h0;
  int          rcnt      = 0;

  // model of who was granted last; reset makes fetch win the first tie
  bit last_gnt_m = 1'b1;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_sign(d_sign), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_sign(mem_sign), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory answers on the (mem_lat+1)-th cycle of mem_req; junk on rdata otherwise.
  always @(negedge clk) begin
    if (mem_req === 1'b1 && rst === 1'b0) begin
      mem_ready = (!mem_never && rcnt == mem_lat);
      mem_rdata = mem_ready ? mem_data : $urandom;
      rcnt++;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      rcnt = 0;
    end
  end

  function automatic logic [107:0] out_bus();
    return {mem_req, mem_write, mem_addr, mem_wdata, mem_size, mem_sign,
            if_valid, if_err, d_valid, d_err, if_rdata[3:0], d_rdata[3:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_write = 0; d_addr = 0;
    d_wdata = 0; d_size = 0; d_sign = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_bus() !== '0) $display("FAIL reset_outputs got=%h want=0", out_bus()); else n_pass++;
    n_checks++; if ({if_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata got=%h want=0", {if_rdata, d_rdata}); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) $display("FAIL idle_mem_req got=%b want=0", mem_req); else n_pass++;
    n_checks++; if ({if_valid, d_valid} !== 2'b00) $display("FAIL idle_valid got=%b want=00", {if_valid, d_valid}); else n_pass++;
    last_gnt_m = 1'b1;
    $display("txn reset done");
  endtask

  task automatic run_txn(input bit is_d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input bit sgn, input int lat, input bit never, input string tag);
    int bytes, mcyc, lat_obs, exp_lat, exp_mcyc;
    bit exp_align, exp_to, seen, fb, ob;
    logic [31:0] data, exp_rdata, rd;
    logic er;
    data = $urandom;
    bytes = is_d ? ((size == 2'b11) ? 0 : (1 << size)) : 4;
    exp_align = (bytes == 0) ? 1'b1 : ((addr % bytes) != 0);
    exp_to    = !exp_align && (never || lat >= TIMEOUT);
    exp_lat   = exp_align ? 1 : (exp_to ? TIMEOUT + 1 : lat + 2);
    exp_mcyc  = exp_align ? 0 : (exp_to ? TIMEOUT : lat + 1);
    exp_rdata = (exp_align || exp_to || (is_d && wr)) ? 32'h0 : data;

    mem_lat = lat; mem_never = never; mem_data = data;
    if (is_d) begin
      d_req = 1; d_write = wr; d_addr = addr; d_wdata = wdata; d_size = size; d_sign = sgn;
    end else begin
      if_req = 1; if_addr = addr;
    end
    seen = 0; fb = 0; ob = 0; mcyc = 0; lat_obs = 0; rd = 0; er = 0;
    for (int c = 1; c <= TIMEOUT + 20; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        mcyc++;
        if (mem_addr !== addr || mem_write !== (is_d && wr) || mem_size !== (is_d ? size : 2'b10) ||
            mem_sign !== (is_d && sgn) || (is_d && mem_wdata !== wdata)) fb = 1;
      end
      if (is_d ? (if_valid !== 0 || if_rdata !== 0 || if_err !== 0)
               : (d_valid !== 0 || d_rdata !== 0 || d_err !== 0)) ob = 1;
      if ((is_d ? d_valid : if_valid) === 1'b1) begin
        seen = 1; lat_obs = c;
        rd = is_d ? d_rdata : if_rdata;
        er = is_d ? d_err : if_err;
        break;
      end
    end
    if_req = 0; d_req = 0;
    last_gnt_m = is_d;
    n_checks++; if (!seen) $display("FAIL %s_valid_seen got=0 want=1", tag); else n_pass++;
    n_checks++; if (lat_obs != exp_lat) $display("FAIL %s_latency got=%0d want=%0d", tag, lat_obs, exp_lat); else n_pass++;
    n_checks++; if (er !== (exp_align || exp_to)) $display("FAIL %s_err got=%b want=%b", tag, er, exp_align || exp_to); else n_pass++;
    n_checks++; if (rd !== exp_rdata) $display("FAIL %s_rdata got=%h want=%h", tag, rd, exp_rdata); else n_pass++;
    n_checks++; if (mcyc != exp_mcyc) $display("FAIL %s_mem_req_cycles got=%0d want=%0d", tag, mcyc, exp_mcyc); else n_pass++;
    n_checks++; if (fb) $display("FAIL %s_mem_fields got=bad want=stable_match", tag); else n_pass++;
    n_checks++; if (ob) $display("FAIL %s_other_side got=active want=quiet", tag); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({if_valid, d_valid, if_err, d_err} !== 4'b0 || {if_rdata, d_rdata} !== 64'h0)
      $display("FAIL %s_pulse_end got=%b want=0000", tag, {if_valid, d_valid, if_err, d_err});
    else n_pass++;
    $display("txn %s %s wr=%0b addr=%h size=%0d lat=%0d never=%0b err=%0b rdata=%h cyc=%0d",
             tag, is_d ? "D" : "IF", wr, addr, size, lat, never, er, rd, lat_obs);
  endtask

  task automatic test_single_fetch();
    int lat_obs;
    mem_data = 32'h8C080004; mem_lat = 3; mem_never = 0;
    if_req = 1; if_addr = 32'h40;
    lat_obs = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && {mem_size, mem_write} !== 3'b100)
        $display("FAIL fetch_fields got=%b want=100", {mem_size, mem_write});
      if (if_valid === 1'b1) begin lat_obs = c; break; end
    end
    if_req = 0;
    n_checks++; if (lat_obs != 5) $display("FAIL fetch_latency got=%0d want=5", lat_obs); else n_pass++;
    n_checks++; if (if_rdata !== 32'h8C080004) $display("FAIL fetch_rdata got=%h want=8c080004", if_rdata); else n_pass++;
    n_checks++; if (if_err !== 1'b0) $display("FAIL fetch_err got=%b want=0", if_err); else n_pass++;
    last_gnt_m = 1'b0;
    @(negedge clk);
    $display("txn single_fetch rdata=%h cyc=%0d", if_rdata, lat_obs);
  endtask

  task automatic test_misaligned();
    run_txn(1, 0, 32'h102, 32'h0, 2'b10, 0, 0, 0, "mis_word");
    run_txn(1, 0, 32'h101, 32'h0, 2'b01, 0, 0, 0, "mis_half");
    run_txn(1, 1, 32'h100, 32'h5, 2'b11, 0, 0, 0, "mis_size");
    run_txn(0, 0, 32'h203, 32'h0, 2'b10, 0, 0, 0, "mis_fetch");
  endtask

  task automatic test_store();
    run_txn(1, 1, 32'h7, 32'hAB, 2'b00, 0, 1, 0, "store");
  endtask

  task automatic test_timeout();
    run_txn(0, 0, 32'h80, 32'h0, 2'b10, 0, 0, 1, "timeout");
    run_txn(0, 0, 32'h84, 32'h0, 2'b10, 0, TIMEOUT - 1, 0, "ready_last");
    run_txn(1, 0, 32'h88, 32'h0, 2'b10, 1, TIMEOUT, 0, "late_ready");
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      run_txn($urandom_range(0, 1), $urandom_range(0, 1), {20'h0, 12'($urandom)}, $urandom,
              2'($urandom), $urandom_range(0, 1), $urandom_range(0, 5), ($urandom_range(0, 7) == 0), "rand");
    end
  endtask

  task automatic test_back_to_back(input int n);
    bit exp, seen, both, id;
    logic [31:0] rd;
    mem_data = $urandom; mem_never = 0; mem_lat = $urandom_range(0, 2);
    if_req = 1; if_addr = {$urandom, 2'b00} & 32'hFFFC;
    d_req = 1; d_write = 0; d_size = 2'b10; d_sign = 0; d_addr = {$urandom, 2'b00} & 32'hFFFC;
    exp = ~last_gnt_m;
    for (int g = 0; g < n; g++) begin
      seen = 0; both = 0; id = 0; rd = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (if_valid === 1'b1 || d_valid === 1'b1) begin
          seen = 1; both = if_valid && d_valid; id = d_valid;
          rd = d_valid ? d_rdata : if_rdata;
          break;
        end
      end
      if (g == n - 1) begin if_req = 0; d_req = 0; end
      n_checks++; if (!seen) $display("FAIL b2b_seen got=0 want=1"); else n_pass++;
      n_checks++; if (both) $display("FAIL b2b_both_valid got=1 want=0"); else n_pass++;
      n_checks++; if (id !== exp) $display("FAIL b2b_grant got=%0d want=%0d", id, exp); else n_pass++;
      n_checks++; if (rd !== mem_data) $display("FAIL b2b_rdata got=%h want=%h", rd, mem_data); else n_pass++;
      $display("txn b2b grant=%s rdata=%h", id ? "D" : "IF", rd);
      if (!seen) begin if_req = 0; d_req = 0; break; end
      last_gnt_m = id;
      exp = ~id;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_issue();
    bit got_req, stray;
    mem_never = 1; if_req = 1; if_addr = 32'h300;
    got_req = 0; stray = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin got_req = 1; break; end
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_checks++; if (!got_req) $display("FAIL rst_issue_reached got=0 want=1"); else n_pass++;
    n_checks++; if (out_bus() !== '0 || {if_rdata, d_rdata} !== 64'h0) $display("FAIL rst_issue_outputs got=%h want=0", out_bus()); else n_pass++;
    rst = 0; if_req = 0; mem_never = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0) stray = 1;
    end
    n_checks++; if (stray) $display("FAIL rst_issue_no_pulse got=activity want=quiet"); else n_pass++;
    last_gnt_m = 1'b1;
    $display("txn reset_mid_issue");
    test_back_to_back(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back(4);
    test_misaligned();
    test_store();
    test_timeout();
    test_random(40);
    test_back_to_back(3);
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
